load_stage: RTL and testbench

- Input (absorb-side) stage of the SHAKE core; the counterpart of the dump stage at the other end of the pipeline.
- Accepts a header word followed by message words over a valid/ready w-bit stream.
- Assembles rate-sized blocks, applies SHAKE padding (0x1F … 0x80), and hands each block to the permutation stage with first/last flags.
- Forwards operation_mode and output_size downstream.

---
 rtl/keccak_pkg.sv | 34 +++
 rtl/load_datapath.sv | 94 +++++++++
 rtl/load_fsm.sv | 97 +++++++++
 rtl/load_stage.sv | 68 ++++++
 tb/tb_load_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared constants and types for the SHAKE core pipeline stages.
package keccak_pkg;

  localparam int unsigned w             = 64;
  localparam int unsigned RATE_SHAKE128 = 1344;
  localparam int unsigned RATE_SHAKE256 = 1088;

  localparam int unsigned RATE_WORDS_128 = RATE_SHAKE128 / w;  // 21
  localparam int unsigned RATE_WORDS_256 = RATE_SHAKE256 / w;  // 17

  localparam logic [7:0] PAD_FIRST = 8'h1F;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'b00,
    MODE_SHAKE256 = 2'b01,
    MODE_RSVD_2   = 2'b10,
    MODE_RSVD_3   = 2'b11
  } shake_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    PAD,
    WAIT
  } load_state_t;

  // Rate in words for a mode; reserved encodings fall back to SHAKE256.
  function automatic logic [4:0] rate_words(input logic [1:0] mode);
    return (shake_mode_t'(mode) == MODE_SHAKE128) ? 5'(RATE_WORDS_128)
                                                  : 5'(RATE_WORDS_256);
  endfunction

endpackage

// File: rtl/load_datapath.sv
// Block buffer, byte masking, SHAKE padding and byte/word counters for
// the load stage.
module load_datapath
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [w-1:0]             data_in,
  input  logic                     hdr_take,
  input  logic                     word_take,
  input  logic                     pad_do,
  input  logic                     blk_clear,
  output logic [RATE_SHAKE128-1:0] rate_input,
  output logic [1:0]               operation_mode,
  output logic [31:0]              output_size,
  output logic                     hdr_zero,
  output logic                     final_word,
  output logic                     block_fill,
  output logic                     last_word,
  output logic                     rem_zero
);

  localparam int unsigned BYTES_MAX = RATE_SHAKE128 / 8;

  logic [RATE_SHAKE128-1:0] buffer;
  logic [RATE_SHAKE128-1:0] padded;
  logic [31:0]              remaining;
  logic [4:0]               word_idx;
  logic [4:0]               rw_last;
  logic [7:0]               rb_last;
  logic [7:0]               pad_pos;
  logic [3:0]               take;
  logic [w-1:0]             word_masked;

  assign rw_last = rate_words(operation_mode) - 5'd1;
  assign rb_last = {rate_words(operation_mode), 3'b000} - 8'd1;

  assign take       = (remaining >= 32'd8) ? 4'd8 : remaining[3:0];
  assign final_word = (remaining <= 32'd8);
  assign last_word  = (word_idx == rw_last);
  assign block_fill = last_word && (take == 4'd8);
  assign rem_zero   = (remaining == '0);
  assign hdr_zero   = (data_in[31:3] == '0);

  assign rate_input = buffer;

  // Zero the bytes of the incoming word that lie beyond the message end.
  always_comb begin
    word_masked = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      if (j < 32'(take)) word_masked[8*j +: 8] = data_in[8*j +: 8];
    end
  end

  // Both pad markers are OR-ed in one pass so a shared byte becomes 0x9F.
  always_comb begin
    padded = buffer;
    for (int unsigned j = 0; j < BYTES_MAX; j++) begin
      if (j == 32'(pad_pos)) padded[8*j +: 8] = padded[8*j +: 8] | PAD_FIRST;
      if (j == 32'(rb_last)) padded[8*j +: 8] = padded[8*j +: 8] | PAD_LAST;
    end
  end

  // Header latch, word writes, padding and per-block clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer         <= '0;
      remaining      <= '0;
      word_idx       <= '0;
      pad_pos        <= '0;
      operation_mode <= '0;
      output_size    <= '0;
    end else if (hdr_take) begin
      buffer         <= '0;
      remaining      <= {3'b000, data_in[31:3]};
      word_idx       <= '0;
      pad_pos        <= '0;
      operation_mode <= data_in[63:62];
      output_size    <= {2'b00, data_in[61:32]};
    end else if (word_take) begin
      buffer[w*word_idx +: w] <= word_masked;
      remaining <= remaining - {28'd0, take};
      word_idx  <= last_word ? '0 : word_idx + 5'd1;
      if (final_word) pad_pos <= {word_idx, 3'b000} + {4'd0, take};
    end else if (pad_do) begin
      buffer <= padded;
    end else if (blk_clear) begin
      buffer   <= '0;
      word_idx <= '0;
      pad_pos  <= '0;
    end
  end

endmodule

// File: rtl/load_fsm.sv
// Control for the absorb-side load stage: state sequencing, handshakes
// and the first/last block flags.
module load_fsm
  import keccak_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic rate_input_ack,
  input  logic hdr_zero,
  input  logic final_word,
  input  logic block_fill,
  input  logic last_word,
  input  logic rem_zero,
  output logic ready_out,
  output logic rate_input_valid,
  output logic first_input_block,
  output logic last_input_block,
  output logic hdr_take,
  output logic word_take,
  output logic pad_do,
  output logic blk_clear
);

  load_state_t state;

  assign hdr_take  = (state == IDLE)   && valid_in && ready_out;
  assign word_take = (state == ABSORB) && valid_in && ready_out;
  assign pad_do    = (state == PAD);
  assign blk_clear = (state == WAIT)   && rate_input_ack;

  // State register with registered handshake outputs and block flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ready_out         <= 1'b0;
      rate_input_valid  <= 1'b0;
      first_input_block <= 1'b0;
      last_input_block  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_out <= 1'b1;
          if (hdr_take) begin
            first_input_block <= 1'b1;
            last_input_block  <= 1'b0;
            if (hdr_zero) begin
              state     <= PAD;
              ready_out <= 1'b0;
            end else begin
              state <= ABSORB;
            end
          end
        end
        ABSORB: begin
          if (word_take) begin
            if (final_word && !block_fill) begin
              state     <= PAD;
              ready_out <= 1'b0;
            end else if (last_word) begin
              state            <= WAIT;
              ready_out        <= 1'b0;
              rate_input_valid <= 1'b1;
            end
          end
        end
        PAD: begin
          state            <= WAIT;
          last_input_block <= 1'b1;
          rate_input_valid <= 1'b1;
        end
        WAIT: begin
          if (rate_input_ack) begin
            rate_input_valid  <= 1'b0;
            first_input_block <= 1'b0;
            if (last_input_block) begin
              state            <= IDLE;
              ready_out        <= 1'b1;
              last_input_block <= 1'b0;
            end else if (rem_zero) begin
              // message ended exactly on a block boundary: pad-only block follows
              state <= PAD;
            end else begin
              state     <= ABSORB;
              ready_out <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          ready_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/load_stage.sv
// Absorb-side input stage of the SHAKE core: header parse, block assembly,
// padding and hand-off to the permutation stage.
module load_stage
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [w-1:0]             data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [RATE_SHAKE128-1:0] rate_input,
  output logic                     rate_input_valid,
  input  logic                     rate_input_ack,
  output logic                     first_input_block,
  output logic                     last_input_block,
  output logic [1:0]               operation_mode,
  output logic [31:0]              output_size
);

  logic hdr_take;
  logic word_take;
  logic pad_do;
  logic blk_clear;
  logic hdr_zero;
  logic final_word;
  logic block_fill;
  logic last_word;
  logic rem_zero;

  load_fsm u_fsm (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .rate_input_ack    (rate_input_ack),
    .hdr_zero          (hdr_zero),
    .final_word        (final_word),
    .block_fill        (block_fill),
    .last_word         (last_word),
    .rem_zero          (rem_zero),
    .ready_out         (ready_out),
    .rate_input_valid  (rate_input_valid),
    .first_input_block (first_input_block),
    .last_input_block  (last_input_block),
    .hdr_take          (hdr_take),
    .word_take         (word_take),
    .pad_do            (pad_do),
    .blk_clear         (blk_clear)
  );

  load_datapath u_dp (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .hdr_take       (hdr_take),
    .word_take      (word_take),
    .pad_do         (pad_do),
    .blk_clear      (blk_clear),
    .rate_input     (rate_input),
    .operation_mode (operation_mode),
    .output_size    (output_size),
    .hdr_zero       (hdr_zero),
    .final_word     (final_word),
    .block_fill     (block_fill),
    .last_word      (last_word),
    .rem_zero       (rem_zero)
  );

endmodule

// File: tb/tb_load_stage.sv
// Directed self-checking bench for load_stage.
module tb_load_stage;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   data_in = '0;
  logic          valid_in = 1'b0;
  logic          rate_input_ack = 1'b0;
  logic          ready_out;
  logic [1343:0] rate_input;
  logic          rate_input_valid;
  logic          first_input_block;
  logic          last_input_block;
  logic [1:0]    operation_mode;
  logic [31:0]   output_size;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] expw [21];
  logic [63:0] tmp;

  always #5 clk = ~clk;

  load_stage dut (
    .clk               (clk),
    .rst               (rst),
    .data_in           (data_in),
    .valid_in          (valid_in),
    .ready_out         (ready_out),
    .rate_input        (rate_input),
    .rate_input_valid  (rate_input_valid),
    .rate_input_ack    (rate_input_ack),
    .first_input_block (first_input_block),
    .last_input_block  (last_input_block),
    .operation_mode    (operation_mode),
    .output_size       (output_size)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int unsigned k);
    return 64'h0123_4567_89AB_CDEF + 64'(k) * 64'h0101_0101_0101_0101;
  endfunction

  function automatic logic [63:0] hdr(input logic [1:0] mode, input logic [29:0] osize,
                                      input logic [31:0] isize);
    return {mode, osize, isize};
  endfunction

  task automatic clear_exp;
    for (int k = 0; k < 21; k++) expw[k] = '0;
  endtask

  task automatic check_block(input string tag);
    for (int k = 0; k < 21; k++)
      check($sformatf("%s_w%0d", tag, k), rate_input[64*k +: 64], expw[k]);
  endtask

  // Present one word and hold it until the DUT takes it.
  task automatic send(input logic [63:0] d);
    int unsigned n = 0;
    @(negedge clk);
    data_in  = d;
    valid_in = 1'b1;
    while (!ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) check("send_timeout", 64'(ready_out), 64'd1);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!rate_input_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rate_input_valid) check({tag, "_timeout"}, 64'(rate_input_valid), 64'd1);
  endtask

  task automatic do_ack;
    @(negedge clk);
    rate_input_ack = 1'b1;
    valid_in       = 1'b0;
    @(posedge clk);
    #1 rate_input_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_out), 64'd0);
    check("rst_valid", 64'(rate_input_valid), 64'd0);
    check("rst_first", 64'(first_input_block), 64'd0);
    check("rst_last",  64'(last_input_block), 64'd0);
    check("rst_mode",  64'(operation_mode), 64'd0);
    check("rst_osize", 64'(output_size), 64'd0);
    clear_exp();
    check_block("rst_blk");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("rel_ready", 64'(ready_out), 64'd1);

    // A: SHAKE128, empty message
    send(hdr(2'b00, 30'd256, 32'd0));
    wait_valid("A");
    clear_exp();
    expw[0]  = 64'h1F;
    expw[20] = 64'h80 << 56;
    check_block("A_blk");
    check("A_first", 64'(first_input_block), 64'd1);
    check("A_last",  64'(last_input_block), 64'd1);
    check("A_osize", 64'(output_size), 64'd256);
    check("A_mode",  64'(operation_mode), 64'd0);
    do_ack();
    check("A_ready", 64'(ready_out), 64'd1);
    check("A_valid", 64'(rate_input_valid), 64'd0);

    // B: SHAKE256, 3 bytes, garbage above the message masked off
    send(hdr(2'b01, 30'd512, 32'd24));
    send(64'hFFFF_FFFF_FF63_6261);
    check("B_lat1", 64'(rate_input_valid), 64'd0);
    @(posedge clk);
    #1 check("B_lat2", 64'(rate_input_valid), 64'd1);
    clear_exp();
    expw[0]  = 64'h0000_0000_1F63_6261;
    expw[16] = 64'h80 << 56;
    check_block("B_blk");
    check("B_mode",  64'(operation_mode), 64'd1);
    check("B_osize", 64'(output_size), 64'd512);
    check("B_first", 64'(first_input_block), 64'd1);
    check("B_last",  64'(last_input_block), 64'd1);
    do_ack();

    // C: SHAKE128, 167 bytes (low size bits set, must be ignored)
    send(hdr(2'b00, 30'd0, 32'd1341));
    for (int k = 0; k < 21; k++) send(pat(k));
    check("C_lat1", 64'(rate_input_valid), 64'd0);
    wait_valid("C");
    for (int k = 0; k < 21; k++) expw[k] = pat(k);
    tmp = pat(20);
    expw[20] = {8'h9F, tmp[55:0]};
    check_block("C_blk");
    check("C_first", 64'(first_input_block), 64'd1);
    check("C_last",  64'(last_input_block), 64'd1);
    do_ack();

    // D: SHAKE128, exactly 168 bytes -> data block then pad-only block
    send(hdr(2'b00, 30'd64, 32'd1344));
    for (int k = 0; k < 21; k++) send(pat(k));
    check("D_lat1", 64'(rate_input_valid), 64'd1);
    for (int k = 0; k < 21; k++) expw[k] = pat(k);
    check_block("D1_blk");
    check("D1_first", 64'(first_input_block), 64'd1);
    check("D1_last",  64'(last_input_block), 64'd0);
    do_ack();
    check("D1_ready", 64'(ready_out), 64'd0);
    wait_valid("D2");
    clear_exp();
    expw[0]  = 64'h1F;
    expw[20] = 64'h80 << 56;
    check_block("D2_blk");
    check("D2_first", 64'(first_input_block), 64'd0);
    check("D2_last",  64'(last_input_block), 64'd1);

    // E: stall in WAIT with valid_in asserted
    @(negedge clk);
    data_in  = 64'hDEAD_BEEF_DEAD_BEEF;
    valid_in = 1'b1;
    repeat (10) @(negedge clk);
    check("E_ready", 64'(ready_out), 64'd0);
    check("E_valid", 64'(rate_input_valid), 64'd1);
    check_block("E_blk");
    do_ack();
    check("E_ready_ack", 64'(ready_out), 64'd1);
    check("E_valid_ack", 64'(rate_input_valid), 64'd0);

    // F: reset in the middle of a message
    send(hdr(2'b00, 30'd1000, 32'd800));
    for (int k = 0; k < 5; k++) send(pat(k));
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("F_ready", 64'(ready_out), 64'd0);
    check("F_valid", 64'(rate_input_valid), 64'd0);
    check("F_first", 64'(first_input_block), 64'd0);
    check("F_last",  64'(last_input_block), 64'd0);
    check("F_mode",  64'(operation_mode), 64'd0);
    check("F_osize", 64'(output_size), 64'd0);
    clear_exp();
    check_block("F_blk");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("F_rel_ready", 64'(ready_out), 64'd1);
    // reserved mode 11 uses the SHAKE256 rate
    send(hdr(2'b11, 30'd128, 32'd8));
    send(64'h0000_0000_0000_00AB);
    wait_valid("F2");
    clear_exp();
    expw[0]  = 64'h1FAB;
    expw[16] = 64'h80 << 56;
    check_block("F2_blk");
    check("F2_mode",  64'(operation_mode), 64'd3);
    check("F2_osize", 64'(output_size), 64'd128);
    check("F2_first", 64'(first_input_block), 64'd1);
    check("F2_last",  64'(last_input_block), 64'd1);
    do_ack();
    check("F2_ready", 64'(ready_out), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
